// File: rtl/axis_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_probe_pkg
//  Description : Shared types, defaults and width helpers for the AXI-Stream
//                probe arbiter and its round-robin sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_probe_pkg;

  // Defaults shared with the probe capture block
  localparam int c_default_data_width = 128;
  localparam int c_default_req_num    = 4;
  localparam int c_default_timeout    = 1024;

  // Grant-id width: at least one bit even for degenerate requester counts
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter must be able to hold TIMEOUT_CYCLES itself (saturating)
  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

  localparam int c_grant_w   = grant_width(c_default_req_num);
  localparam int c_tmo_cnt_w = cnt_width(c_default_timeout);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    WAIT_RSP = 2'd2,
    CHK      = 2'd3
  } arb_state_e;

endpackage : axis_probe_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Rotates the request
//                vector so the slot after last_ptr sits at bit 0, picks the
//                lowest set bit, then rotates the index back.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import axis_probe_pkg::*;
#(
  parameter int N = 4,
  localparam int c_pw = grant_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [c_pw-1:0] last_ptr,
  output logic            valid,
  output logic [c_pw-1:0] winner
);

  localparam int              c_sw = c_pw + 1;
  localparam logic [c_sw-1:0] c_n  = c_sw'(N);

  logic [c_sw-1:0]  w_shift;
  logic [c_sw-1:0]  w_sum;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [c_pw-1:0]  w_enc;

  // Rotate, priority-encode lowest set bit, unrotate modulo N
  always_comb begin
    w_shift = {1'b0, last_ptr} + c_sw'(1);
    w_dbl   = {req, req} >> w_shift;
    w_rot   = w_dbl[N-1:0];
    w_enc   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = c_pw'(i);
    end
    w_sum = {1'b0, w_enc} + w_shift;
    if (w_sum >= c_n) w_sum = w_sum - c_n;
    valid  = |req;
    winner = w_sum[c_pw-1:0];
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/axis_probe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_probe_arbiter
//  Description : Shares one AXI-Stream probe between REQ_NUM host channels
//                with packet-level round-robin. The grant is held from the
//                request packet through the matching response tlast, with a
//                response timeout and sticky per-requester error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_probe_arbiter
  import axis_probe_pkg::*;
#(
  parameter int C_DATA_WIDTH   = c_default_data_width,
  parameter int REQ_NUM        = c_default_req_num,
  parameter int TIMEOUT_CYCLES = c_default_timeout
) (
  input  logic                              s_axis_aclk,
  input  logic                              s_axis_areset,
  // requester request streams
  input  logic [REQ_NUM-1:0]                req_s_axis_tvalid,
  output logic [REQ_NUM-1:0]                req_s_axis_tready,
  input  logic [REQ_NUM-1:0]                req_s_axis_tlast,
  input  logic [REQ_NUM*C_DATA_WIDTH-1:0]   req_s_axis_tdata,
  input  logic [REQ_NUM*C_DATA_WIDTH/8-1:0] req_s_axis_tkeep,
  // requester response streams (payload broadcast)
  output logic [REQ_NUM-1:0]                rsp_m_axis_tvalid,
  input  logic [REQ_NUM-1:0]                rsp_m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]           rsp_m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]         rsp_m_axis_tkeep,
  output logic                              rsp_m_axis_tlast,
  // stream into the probe
  output logic                              prb_m_axis_tvalid,
  input  logic                              prb_m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]           prb_m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]         prb_m_axis_tkeep,
  output logic                              prb_m_axis_tlast,
  // stream from the probe
  input  logic                              prb_s_axis_tvalid,
  output logic                              prb_s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]           prb_s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]         prb_s_axis_tkeep,
  input  logic                              prb_s_axis_tlast,
  // status
  input  logic                              prb_bad_packet,
  input  logic                              err_clear,
  output logic [grant_width(REQ_NUM)-1:0]   grant_id,
  output logic                              busy,
  output logic [REQ_NUM-1:0]                bad_pkt_err,
  output logic [REQ_NUM-1:0]                timeout_err,
  output logic                              stray_rsp
);

  localparam int              c_gw       = grant_width(REQ_NUM);
  localparam int              c_cw       = cnt_width(TIMEOUT_CYCLES);
  localparam int              c_kw       = C_DATA_WIDTH / 8;
  localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TIMEOUT_CYCLES - 1);

  arb_state_e          r_state;
  arb_state_e          w_next_state;
  logic [c_gw-1:0]     r_rr_ptr;
  logic [c_gw-1:0]     r_grant_id;
  logic [c_cw-1:0]     r_cnt;
  logic [REQ_NUM-1:0]  r_bad_pkt_err;
  logic [REQ_NUM-1:0]  r_timeout_err;
  logic                r_stray_rsp;

  logic                w_arb_valid;
  logic [c_gw-1:0]     w_arb_winner;
  logic [REQ_NUM-1:0]  w_gnt_onehot;
  logic                w_rsp_hs;
  logic                w_timeout;
  logic                w_stray;

  rr_arbiter #(
    .N (REQ_NUM)
  ) u_rr_arbiter (
    .req      (req_s_axis_tvalid),
    .last_ptr (r_rr_ptr),
    .valid    (w_arb_valid),
    .winner   (w_arb_winner)
  );

  // Payload paths are pure passthrough; only the handshakes are steered
  assign prb_m_axis_tdata = req_s_axis_tdata[r_grant_id*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign prb_m_axis_tkeep = req_s_axis_tkeep[r_grant_id*c_kw +: c_kw];
  assign prb_m_axis_tlast = req_s_axis_tlast[r_grant_id];
  assign rsp_m_axis_tdata = prb_s_axis_tdata;
  assign rsp_m_axis_tkeep = prb_s_axis_tkeep;
  assign rsp_m_axis_tlast = prb_s_axis_tlast;

  assign grant_id    = r_grant_id;
  assign busy        = (r_state != IDLE);
  assign bad_pkt_err = r_bad_pkt_err;
  assign timeout_err = r_timeout_err;
  assign stray_rsp   = r_stray_rsp;

  // Next-state and handshake steering; every valid/ready is forced low in reset
  always_comb begin
    w_next_state      = r_state;
    req_s_axis_tready = '0;
    rsp_m_axis_tvalid = '0;
    prb_m_axis_tvalid = 1'b0;
    prb_s_axis_tready = 1'b0;
    w_gnt_onehot      = '0;
    w_gnt_onehot[r_grant_id] = 1'b1;
    w_rsp_hs          = 1'b0;
    w_timeout         = 1'b0;
    w_stray           = 1'b0;
    case (r_state)
      IDLE: begin
        // drain anything the probe sends when nobody owns it
        prb_s_axis_tready = 1'b1;
        w_stray           = prb_s_axis_tvalid;
        if (w_arb_valid) w_next_state = FWD;
      end
      FWD: begin
        prb_m_axis_tvalid             = req_s_axis_tvalid[r_grant_id];
        req_s_axis_tready[r_grant_id] = prb_m_axis_tready;
        if (req_s_axis_tvalid[r_grant_id] && prb_m_axis_tready &&
            req_s_axis_tlast[r_grant_id])
          w_next_state = CHK;
      end
      CHK: begin
        w_next_state = WAIT_RSP;
      end
      WAIT_RSP: begin
        rsp_m_axis_tvalid[r_grant_id] = prb_s_axis_tvalid;
        prb_s_axis_tready             = rsp_m_axis_tready[r_grant_id];
        w_rsp_hs = prb_s_axis_tvalid & rsp_m_axis_tready[r_grant_id];
        if (w_rsp_hs && prb_s_axis_tlast) begin
          w_next_state = IDLE;
        end else if (!w_rsp_hs && (r_cnt == c_tmo_last)) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (s_axis_areset) begin
      req_s_axis_tready = '0;
      rsp_m_axis_tvalid = '0;
      prb_m_axis_tvalid = 1'b0;
      prb_s_axis_tready = 1'b0;
      w_stray           = 1'b0;
    end
  end

  // State register, grant capture and round-robin pointer update
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= c_gw'(REQ_NUM - 1);
      r_grant_id <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && w_arb_valid) begin
        r_grant_id <= w_arb_winner;
        r_rr_ptr   <= w_arb_winner;
      end
    end
  end

  // Response timeout counter: cleared outside WAIT_RSP and on every beat, saturating
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_cnt <= '0;
    end else if ((r_state != WAIT_RSP) || w_rsp_hs) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  // Sticky error flags; a new set wins over a simultaneous clear
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_bad_pkt_err <= '0;
      r_timeout_err <= '0;
      r_stray_rsp   <= 1'b0;
    end else begin
      r_bad_pkt_err <= (r_bad_pkt_err & ~{REQ_NUM{err_clear}}) |
                       (((r_state == CHK) && prb_bad_packet) ? w_gnt_onehot : '0);
      r_timeout_err <= (r_timeout_err & ~{REQ_NUM{err_clear}}) |
                       (w_timeout ? w_gnt_onehot : '0);
      r_stray_rsp   <= (r_stray_rsp & ~err_clear) | w_stray;
    end
  end

endmodule : axis_probe_arbiter
`default_nettype wire

// File: tb/tb_axis_probe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_probe_arbiter
//  Description : Self-checking bench for axis_probe_arbiter: arbitration
//                vector table, directed corner sequences and a randomized
//                packet run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_probe_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_tvalid, req_tready, req_tlast;
  logic [N*DW-1:0] req_tdata;
  logic [N*KW-1:0] req_tkeep;
  logic [N-1:0]    rsp_tvalid, rsp_tready;
  logic [DW-1:0]   rsp_tdata;
  logic [KW-1:0]   rsp_tkeep;
  logic            rsp_tlast;
  logic            pm_tvalid, pm_tready, pm_tlast;
  logic [DW-1:0]   pm_tdata;
  logic [KW-1:0]   pm_tkeep;
  logic            ps_tvalid, ps_tready, ps_tlast;
  logic [DW-1:0]   ps_tdata;
  logic [KW-1:0]   ps_tkeep;
  logic            bad_packet, err_clear;
  logic [1:0]      grant_id;
  logic            busy, stray_rsp;
  logic [N-1:0]    bad_pkt_err, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_probe_arbiter #(
    .C_DATA_WIDTH   (DW),
    .REQ_NUM        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .s_axis_aclk       (clk),
    .s_axis_areset     (rst),
    .req_s_axis_tvalid (req_tvalid),
    .req_s_axis_tready (req_tready),
    .req_s_axis_tlast  (req_tlast),
    .req_s_axis_tdata  (req_tdata),
    .req_s_axis_tkeep  (req_tkeep),
    .rsp_m_axis_tvalid (rsp_tvalid),
    .rsp_m_axis_tready (rsp_tready),
    .rsp_m_axis_tdata  (rsp_tdata),
    .rsp_m_axis_tkeep  (rsp_tkeep),
    .rsp_m_axis_tlast  (rsp_tlast),
    .prb_m_axis_tvalid (pm_tvalid),
    .prb_m_axis_tready (pm_tready),
    .prb_m_axis_tdata  (pm_tdata),
    .prb_m_axis_tkeep  (pm_tkeep),
    .prb_m_axis_tlast  (pm_tlast),
    .prb_s_axis_tvalid (ps_tvalid),
    .prb_s_axis_tready (ps_tready),
    .prb_s_axis_tdata  (ps_tdata),
    .prb_s_axis_tkeep  (ps_tkeep),
    .prb_s_axis_tlast  (ps_tlast),
    .prb_bad_packet    (bad_packet),
    .err_clear         (err_clear),
    .grant_id          (grant_id),
    .busy              (busy),
    .bad_pkt_err       (bad_pkt_err),
    .timeout_err       (timeout_err),
    .stray_rsp         (stray_rsp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_drive();
    req_tvalid = '0; req_tlast = '0; req_tdata = '0; req_tkeep = '1;
    rsp_tready = '1; pm_tready = 1'b1;
    ps_tvalid = 1'b0; ps_tdata = '0; ps_tkeep = '1; ps_tlast = 1'b0;
    bad_packet = 1'b0; err_clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-beat request and response through one arbitration round
  task automatic run_vec(input logic [3:0] mask, input logic [1:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << exp;
    req_tvalid = mask; req_tlast = 4'hF;
    for (int i = 0; i < N; i++) req_tdata[i*DW +: DW] = 32'hD0 + i;
    #1 chk("vec_idle_busy", busy, 0);
    tick();
    #1 chk("vec_grant", grant_id, exp);
    chk("vec_prb_valid", pm_tvalid, 1);
    chk("vec_prb_data", pm_tdata, 32'hD0 + exp);
    chk("vec_req_ready", req_tready, oh);
    tick();
    req_tvalid = '0;
    tick();
    ps_tvalid = 1'b1; ps_tdata = 32'hE0 + exp; ps_tlast = 1'b1;
    #1 chk("vec_rsp_route", rsp_tvalid, oh);
    chk("vec_rsp_data", rsp_tdata, 32'hE0 + exp);
    tick();
    ps_tvalid = 1'b0; ps_tlast = 1'b0;
    #1 chk("vec_done_busy", busy, 0);
  endtask

  // Reference model storage for the randomized run
  logic [31:0] pd [N][3][6];
  int          plen [N][3];
  int          npk [N];
  int          cur_pk [N];
  int          cur_bt [N];
  int          ord_r[$];
  int          ord_k[$];
  logic [31:0] rq_d[$];
  logic        rq_l[$];

  task automatic run_random();
    int total, ptr, pin, pbeat, pout, cyc, r, k, c, own;
    int rem [N];
    bit s_held, found;
    logic [3:0] own_oh;
    total = 0;
    for (int i = 0; i < N; i++) begin
      npk[i] = $urandom_range(1, 3);
      cur_pk[i] = 0; cur_bt[i] = 0; rem[i] = npk[i];
      total += npk[i];
      for (int j = 0; j < 3; j++) begin
        plen[i][j] = $urandom_range(1, 6);
        for (int b = 0; b < 6; b++) pd[i][j][b] = $urandom;
      end
    end
    // Expected packet order: after each grant, next nonempty requester cyclically
    ptr = N - 1;
    for (int p = 0; p < total; p++) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        c = (ptr + i) % N;
        if (!found && rem[c] > 0) begin
          found = 1'b1;
          ord_r.push_back(c);
          ord_k.push_back(npk[c] - rem[c]);
          rem[c]--;
          ptr = c;
        end
      end
    end
    pin = 0; pbeat = 0; pout = 0; cyc = 0; s_held = 1'b0;
    while (pout < total && cyc < 20000) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (cur_pk[i] < npk[i]) begin
          req_tvalid[i] = 1'b1;
          req_tdata[i*DW +: DW] = pd[i][cur_pk[i]][cur_bt[i]];
          req_tlast[i] = (cur_bt[i] == plen[i][cur_pk[i]] - 1);
        end else begin
          req_tvalid[i] = 1'b0;
          req_tlast[i] = 1'b0;
        end
        rsp_tready[i] = ($urandom_range(0, 3) != 0);
      end
      pm_tready = ($urandom_range(0, 3) != 0);
      if (rq_d.size() > 0) begin
        if (!s_held) ps_tvalid = ($urandom_range(0, 3) != 0);
        ps_tdata = rq_d[0];
        ps_tlast = rq_l[0];
      end else begin
        ps_tvalid = 1'b0;
        ps_tlast = 1'b0;
      end
      #1;
      if (pm_tvalid && pm_tready) begin
        if (pin >= total) begin
          chk("rnd_extra_req_beat", 1, 0);
        end else begin
          r = ord_r[pin]; k = ord_k[pin];
          chk("rnd_grant", grant_id, r);
          chk("rnd_req_data", pm_tdata, pd[r][k][pbeat]);
          chk("rnd_req_last", pm_tlast, (pbeat == plen[r][k] - 1));
          rq_d.push_back(pd[r][k][pbeat] ^ 32'h5A5A_5A5A);
          rq_l.push_back(pbeat == plen[r][k] - 1);
          if (pbeat == plen[r][k] - 1) begin pin++; pbeat = 0; end
          else pbeat++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_tvalid[i] && req_tready[i]) begin
          if (req_tlast[i]) begin cur_pk[i]++; cur_bt[i] = 0; end
          else cur_bt[i]++;
        end
      end
      own = (pout < total) ? ord_r[pout] : 0;
      own_oh = 4'b0001 << own;
      if (rsp_tvalid != '0) chk("rnd_rsp_stray_route", rsp_tvalid & ~own_oh, 0);
      if (ps_tvalid && ps_tready) begin
        chk("rnd_rsp_valid", rsp_tvalid, own_oh);
        chk("rnd_rsp_accept", rsp_tready[own], 1);
        chk("rnd_rsp_data", rsp_tdata, rq_d[0]);
        chk("rnd_rsp_last", rsp_tlast, rq_l[0]);
        if (rq_l[0]) pout++;
        void'(rq_d.pop_front());
        void'(rq_l.pop_front());
        s_held = 1'b0;
      end else begin
        s_held = ps_tvalid;
      end
      tick();
    end
    chk("rnd_all_rsp_packets", pout, total);
    chk("rnd_all_req_packets", pin, total);
    chk("rnd_no_stray", stray_rsp, 0);
    chk("rnd_no_timeout", timeout_err, 0);
    idle_drive();
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t vt [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    vt[0]  = '{4'b1111, 2'd0};
    vt[1]  = '{4'b1111, 2'd1};
    vt[2]  = '{4'b1111, 2'd2};
    vt[3]  = '{4'b1111, 2'd3};
    vt[4]  = '{4'b1111, 2'd0};
    vt[5]  = '{4'b0101, 2'd2};
    vt[6]  = '{4'b0101, 2'd0};
    vt[7]  = '{4'b1000, 2'd3};
    vt[8]  = '{4'b0011, 2'd0};
    vt[9]  = '{4'b1010, 2'd1};
    vt[10] = '{4'b1010, 2'd3};
    vt[11] = '{4'b0100, 2'd2};
    vt[12] = '{4'b1011, 2'd3};

    // Reset state, sampled while reset is still held
    rst = 1'b1;
    idle_drive();
    tick();
    tick();
    #1 chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_flags", {bad_pkt_err, timeout_err, stray_rsp}, 0);
    chk("rst_valids_readies", {req_tready, rsp_tvalid, pm_tvalid, ps_tready}, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 13; v++) run_vec(vt[v].mask, vt[v].exp_gnt);

    // Single requester 2, 10-beat request and 10-beat response
    req_tvalid = 4'b0100;
    req_tdata[2*DW +: DW] = 32'h200;
    req_tlast = 4'b0000;
    tick();
    #1 chk("single_grant", grant_id, 2);
    for (int b = 0; b < 10; b++) begin
      req_tdata[2*DW +: DW] = 32'h200 + b;
      req_tlast[2] = (b == 9);
      #1 chk("single_prb_data", pm_tdata, 32'h200 + b);
      chk("single_prb_last", pm_tlast, (b == 9));
      tick();
    end
    req_tvalid = '0; req_tlast = '0;
    tick();
    for (int b = 0; b < 10; b++) begin
      ps_tvalid = 1'b1; ps_tdata = 32'h300 + b; ps_tlast = (b == 9);
      #1 chk("single_rsp_route", rsp_tvalid, 4'b0100);
      chk("single_rsp_data", rsp_tdata, 32'h300 + b);
      chk("single_busy", busy, 1);
      tick();
    end
    ps_tvalid = 1'b0; ps_tlast = 1'b0;
    #1 chk("single_busy_drop", busy, 0);

    // Bad packet on requester 1 (9 beats), then set on 3 concurrent with clear
    req_tvalid = 4'b0010;
    tick();
    for (int b = 0; b < 9; b++) begin
      req_tdata[1*DW +: DW] = 32'h100 + b;
      req_tlast[1] = (b == 8);
      tick();
    end
    req_tvalid = '0; req_tlast = '0;
    bad_packet = 1'b1;
    tick();
    bad_packet = 1'b0;
    #1 chk("bad_pkt_req1", bad_pkt_err, 4'b0010);
    ps_tvalid = 1'b1; ps_tlast = 1'b1;
    tick();
    ps_tvalid = 1'b0; ps_tlast = 1'b0;
    req_tvalid = 4'b1000; req_tlast = 4'b1000;
    tick();
    tick();
    req_tvalid = '0; req_tlast = '0;
    bad_packet = 1'b1; err_clear = 1'b1;
    tick();
    bad_packet = 1'b0; err_clear = 1'b0;
    #1 chk("bad_pkt_set_over_clear", bad_pkt_err, 4'b1000);
    ps_tvalid = 1'b1; ps_tlast = 1'b1;
    tick();
    ps_tvalid = 1'b0; ps_tlast = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1 chk("bad_pkt_cleared", bad_pkt_err, 4'b0000);

    // Response timeout on requester 0, then a late beat drained as stray
    req_tvalid = 4'b0001; req_tlast = 4'b0001;
    tick();
    tick();
    req_tvalid = '0; req_tlast = '0;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      #1 chk("tmo_pending", {busy, timeout_err}, {1'b1, 4'b0000});
    end
    tick();
    #1 chk("tmo_flag", timeout_err, 4'b0001);
    chk("tmo_idle", busy, 0);
    ps_tvalid = 1'b1; ps_tlast = 1'b1;
    #1 chk("late_not_routed", rsp_tvalid, 0);
    chk("late_drained", ps_tready, 1);
    tick();
    ps_tvalid = 1'b0; ps_tlast = 1'b0;
    #1 chk("late_stray", stray_rsp, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    #1 chk("clear_tmo_stray", {timeout_err, stray_rsp}, 0);

    // Reset asserted while requester 1 is presenting beat 5 of 10
    req_tvalid = 4'b0010;
    tick();
    for (int b = 0; b < 4; b++) begin
      req_tdata[1*DW +: DW] = 32'h400 + b;
      tick();
    end
    req_tdata[1*DW +: DW] = 32'h404;
    rst = 1'b1;
    tick();
    #1 chk("midrst_busy", busy, 0);
    chk("midrst_valids_readies", {req_tready, rsp_tvalid, pm_tvalid, ps_tready}, 0);
    chk("midrst_grant", grant_id, 0);
    rst = 1'b0;
    req_tvalid = 4'b1111; req_tlast = 4'b1111;
    tick();
    #1 chk("post_rst_first_grant", grant_id, 0);

    // Randomized backpressure run against the packet-level model
    do_reset();
    tick();
    run_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axis_probe_arbiter
`default_nettype wire
